// File: rtl/ip_vector_loader.sv
// Packs (activation, weight) beats into double-buffered WIDTH-lane vectors with bias and tag.
// Latency: vector presented right after its closing beat's edge when the read bank is empty.
// Backpressure: s_ready drops only while the write bank is still full; vec_ready frees a bank.
module ip_vector_loader #(
    parameter int WIDTH = 8,
    parameter int ID_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [31:0]           s_data,
    input  logic [31:0]           s_weight,
    input  logic [31:0]           s_bias,
    input  logic                  s_last,
    output logic [32*WIDTH-1:0]   in_data,
    output logic [32*WIDTH-1:0]   weights,
    output logic [31:0]           bias,
    output logic [ID_W-1:0]       vec_id,
    output logic                  vec_valid,
    input  logic                  vec_ready
);

    localparam int LW = $clog2(WIDTH);

    logic [31:0]     dat_mem  [2][WIDTH];
    logic [31:0]     wgt_mem  [2][WIDTH];
    logic [31:0]     bias_mem [2];
    logic [ID_W-1:0] tag_mem  [2];

    logic [1:0]      full;
    logic            wsel;
    logic            rsel;
    logic [LW-1:0]   lane;
    logic [ID_W-1:0] id_cnt;

    logic accept;
    logic close_vec;
    logic consume;

    assign s_ready   = reset && !full[wsel];
    assign vec_valid = full[rsel];
    assign accept    = s_valid && s_ready;
    assign close_vec = accept && (s_last || (lane == LW'(WIDTH - 1)));
    assign consume   = vec_valid && vec_ready;

    // close and consume never target the same bank: close needs it empty, consume needs it full
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full   <= '0;
            wsel   <= 1'b0;
            rsel   <= 1'b0;
            lane   <= '0;
            id_cnt <= '0;
        end else begin
            if (close_vec) begin
                full[wsel] <= 1'b1;
                wsel       <= ~wsel;
                lane       <= '0;
                id_cnt     <= id_cnt + 1'b1;
            end else if (accept) begin
                lane <= lane + 1'b1;
            end
            if (consume) begin
                full[rsel] <= 1'b0;
                rsel       <= ~rsel;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < WIDTH; i++) begin
                    dat_mem[b][i] <= '0;
                    wgt_mem[b][i] <= '0;
                end
                bias_mem[b] <= '0;
                tag_mem[b]  <= '0;
            end
        end else if (accept) begin
            // the first beat wipes stale lanes so short vectors read +0.0 beyond their end
            if (lane == '0) begin
                for (int i = 0; i < WIDTH; i++) begin
                    dat_mem[wsel][i] <= (i == 0) ? s_data : 32'h0;
                    wgt_mem[wsel][i] <= (i == 0) ? s_weight : 32'h0;
                end
                bias_mem[wsel] <= s_bias;
            end else begin
                dat_mem[wsel][lane] <= s_data;
                wgt_mem[wsel][lane] <= s_weight;
            end
            if (close_vec) begin
                tag_mem[wsel] <= id_cnt;
            end
        end
    end

    always_comb begin
        in_data = '0;
        weights = '0;
        for (int i = 0; i < WIDTH; i++) begin
            in_data[32*i +: 32] = dat_mem[rsel][i];
            weights[32*i +: 32] = wgt_mem[rsel][i];
        end
        bias   = bias_mem[rsel];
        vec_id = tag_mem[rsel];
    end

endmodule

// File: tb/tb_ip_vector_loader.sv
// Randomized scoreboard bench for ip_vector_loader (WIDTH=8, ID_W=8).
module tb_ip_vector_loader;

    localparam int W = 8;

    typedef struct {
        logic [32*W-1:0] d;
        logic [32*W-1:0] w;
        logic [31:0]     b;
        logic [7:0]      id;
    } exp_t;

    logic            clk;
    logic            reset;
    logic            s_valid;
    logic            s_ready;
    logic [31:0]     s_data;
    logic [31:0]     s_weight;
    logic [31:0]     s_bias;
    logic            s_last;
    logic [32*W-1:0] in_data;
    logic [32*W-1:0] weights;
    logic [31:0]     bias;
    logic [7:0]      vec_id;
    logic            vec_valid;
    logic            vec_ready;

    ip_vector_loader #(.WIDTH(W), .ID_W(8)) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_weight(s_weight), .s_bias(s_bias), .s_last(s_last),
        .in_data(in_data), .weights(weights), .bias(bias), .vec_id(vec_id),
        .vec_valid(vec_valid), .vec_ready(vec_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        q[$];
    logic [7:0]  model_id;
    logic [31:0] ftab [W];
    int          checks;
    int          failures;
    int          rdy_mode;
    bit          done;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [31:0] w, input logic [31:0] b,
                             input logic last, output bit ok, output bit stalled);
        bit acc;
        s_valid  = 1'b1;
        s_data   = d;
        s_weight = w;
        s_bias   = b;
        s_last   = last;
        ok       = 1'b0;
        stalled  = 1'b0;
        for (int c = 0; c < 200; c++) begin
            acc = s_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                ok = 1'b1;
                break;
            end
            stalled = 1'b1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (!ok) chk("beat_accept_timeout", 0, 1);
    endtask

    task automatic send_vec(input int n, input bit directed, input bit nostall, input bit chk_valid);
        exp_t e;
        bit ok, st, any_stall;
        logic [31:0] d, w, b;
        logic last;
        e.d = '0;
        e.w = '0;
        e.b = directed ? 32'h3F00_0000 : $urandom;
        e.id = model_id;
        any_stall = 1'b0;
        for (int i = 0; i < n; i++) begin
            d = directed ? ftab[i] : $urandom;
            w = directed ? 32'h4000_0000 : $urandom;
            b = (i == 0) ? e.b : $urandom;
            last = (i == n - 1) ? ((n < W) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
            e.d[32*i +: 32] = d;
            e.w[32*i +: 32] = w;
            send_beat(d, w, b, last, ok, st);
            any_stall |= st;
            if (!ok) return;
        end
        q.push_back(e);
        model_id++;
        if (nostall) chk("no_stall", any_stall, 0);
        if (chk_valid) chk("valid_after_close", vec_valid, 1);
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 500 && q.size() != 0; c++) @(posedge clk);
        #1;
        chk("drain", q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tagname);
        chk({tagname, "_vec_valid"}, vec_valid, 0);
        chk({tagname, "_vec_id"}, vec_id, 0);
        chk({tagname, "_in_data"}, in_data, 0);
        chk({tagname, "_weights"}, weights, 0);
        chk({tagname, "_bias"}, bias, 0);
        chk({tagname, "_s_ready"}, s_ready, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok, st;
        reset = 1'b0; s_valid = 1'b0; s_data = '0; s_weight = '0; s_bias = '0; s_last = 1'b0;
        vec_ready = 1'b0; rdy_mode = 1; done = 1'b0; checks = 0; failures = 0; model_id = '0;
        ftab = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                 32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};
        fork
            // scoreboard monitor: every handshake must match the oldest closed vector
            while (!done) begin
                @(negedge clk);
                if (vec_valid && vec_ready) begin
                    if (q.size() == 0) begin
                        chk("spurious_vec", 1, 0);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("in_data", in_data, e.d);
                        chk("weights", weights, e.w);
                        chk("bias", bias, e.b);
                        chk("vec_id", vec_id, e.id);
                    end
                end
            end
            while (!done) begin
                @(posedge clk);
                #2;
                case (rdy_mode)
                    0:       vec_ready = 1'b0;
                    1:       vec_ready = 1'b1;
                    default: vec_ready = 1'($urandom_range(0, 1));
                endcase
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                check_reset_outputs("reset");
                reset = 1'b1;
                @(posedge clk);
                #1;
                chk("s_ready_after_release", s_ready, 1);

                send_vec(W, 1'b1, 1'b1, 1'b1);
                send_vec(3, 1'b1, 1'b1, 1'b1);
                wait_drain();

                rdy_mode = 0;
                @(posedge clk);
                #1;
                fork
                    begin
                        send_vec(W, 1'b0, 1'b0, 1'b0);
                        send_vec(W, 1'b0, 1'b0, 1'b0);
                        send_vec(4, 1'b0, 1'b0, 1'b0);
                    end
                    begin
                        repeat (20) @(posedge clk);
                        #1;
                        chk("bp_s_ready_low", s_ready, 0);
                        chk("bp_vec_valid", vec_valid, 1);
                        rdy_mode = 1;
                        @(posedge clk);
                        #1;
                        chk("bp_s_ready_rise", s_ready, 1);
                    end
                join
                wait_drain();

                rdy_mode = 2;
                for (int v = 0; v < 60; v++) send_vec($urandom_range(1, W), 1'b0, 1'b0, 1'b0);
                rdy_mode = 1;
                wait_drain();

                for (int v = 0; v < 257; v++) send_vec($urandom_range(1, W), 1'b0, 1'b1, 1'b0);
                wait_drain();

                for (int i = 0; i < 4; i++)
                    send_beat($urandom, $urandom, $urandom, 1'b0, ok, st);
                reset = 1'b0;
                #1;
                check_reset_outputs("midfill");
                repeat (2) @(posedge clk);
                #1;
                reset = 1'b1;
                model_id = '0;
                @(posedge clk);
                #1;
                chk("s_ready_after_midfill", s_ready, 1);
                send_vec(W, 1'b1, 1'b1, 1'b1);
                send_vec(2, 1'b0, 1'b1, 1'b1);
                wait_drain();
                done = 1'b1;
            end
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
